// File: rtl/rx_dco_loop_ctrl.sv
// rx_dco_loop_ctrl: digital CDR loop filter and sequencer driving the RX DCO code.
// A PI filter accumulates bang-bang phase-detector decisions into a fixed-point integrator.
// The loop runs IDLE -> ACQ (high gain) -> TRACK (low gain) and reports lock from TRACK.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 loop enable; low forces IDLE and freezes the integrator
//   pd_valid           one phase-detector decision per cycle when high
//   pd_up / pd_dn      raise / lower the code (both or neither = no error)
//   ovr_load/ovr_code  one-cycle override of integrator and code
//   code               registered DCO code (higher = faster clock)
//   state              0 = IDLE, 1 = ACQ, 2 = TRACK
//   locked             registered lock indicator
//   sat                a clamp was active on the last update
`timescale 1ns/1ps
module rx_dco_loop_ctrl #(
    parameter int unsigned CODE_WIDTH  = 14,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned CODE_INIT   = 8192,
    parameter int unsigned KP_ACQ_LOG2 = 10,
    parameter int unsigned KI_ACQ_LOG2 = 8,
    parameter int unsigned KP_TRK_LOG2 = 8,
    parameter int unsigned KI_TRK_LOG2 = 4,
    parameter int unsigned ACQ_UPDATES = 256,
    parameter int unsigned LOCK_WIN    = 64,
    parameter int unsigned LOCK_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pd_valid,
    input  logic                  pd_up,
    input  logic                  pd_dn,
    input  logic                  ovr_load,
    input  logic [CODE_WIDTH-1:0] ovr_code,
    output logic [CODE_WIDTH-1:0] code,
    output logic [1:0]            state,
    output logic                  locked,
    output logic                  sat
);

    localparam int unsigned IW = CODE_WIDTH + FRAC_BITS;  // integrator width
    localparam int unsigned SW = IW + 2;                   // signed working width
    localparam int unsigned AW = $clog2(ACQ_UPDATES);
    localparam int unsigned WW = $clog2(LOCK_WIN);
    localparam int unsigned NW = WW + 2;                   // holds +/-LOCK_WIN

    localparam logic signed [SW-1:0] IntMax  = {2'b00, {IW{1'b1}}};
    localparam logic signed [SW-1:0] CodeMax = {{(SW-CODE_WIDTH){1'b0}}, {CODE_WIDTH{1'b1}}};
    localparam logic signed [NW-1:0] Thresh  = NW'(LOCK_THRESH);

    typedef enum logic [1:0] {StIdle = 2'd0, StAcq = 2'd1, StTrack = 2'd2} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           int_q, int_d;
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic                    locked_q, locked_d;
    logic                    sat_q, sat_d;
    logic [AW-1:0]           acq_cnt_q, acq_cnt_d;
    logic [WW-1:0]           win_cnt_q, win_cnt_d;
    logic signed [NW-1:0]    net_q, net_d;

    logic                    e_pos, e_neg, update, acq_last, win_last;
    logic signed [SW-1:0]    ki_step, kp_step, e_ki, e_kp;
    logic signed [SW-1:0]    int_sum, int_clamp, kick_sum, code_sh;
    logic                    int_lo, int_hi, code_lo, code_hi;
    logic [CODE_WIDTH-1:0]   code_clamp;
    logic signed [NW-1:0]    e_net, net_sum, net_abs;

    assign e_pos    = pd_up & ~pd_dn;
    assign e_neg    = pd_dn & ~pd_up;
    assign update   = pd_valid & en & (state_q != StIdle);
    assign acq_last = (acq_cnt_q == AW'(ACQ_UPDATES - 1));
    assign win_last = (win_cnt_q == WW'(LOCK_WIN - 1));

    // PI datapath: integrator is clamped first, then the proportional kick rides on top of it.
    always_comb begin
        ki_step   = (state_q == StAcq) ? (SW'(1) << KI_ACQ_LOG2) : (SW'(1) << KI_TRK_LOG2);
        kp_step   = (state_q == StAcq) ? (SW'(1) << KP_ACQ_LOG2) : (SW'(1) << KP_TRK_LOG2);
        e_ki      = e_pos ? ki_step : (e_neg ? -ki_step : '0);
        e_kp      = e_pos ? kp_step : (e_neg ? -kp_step : '0);
        int_sum   = $signed({2'b00, int_q}) + e_ki;
        int_lo    = int_sum < 0;
        int_hi    = int_sum > IntMax;
        int_clamp = int_lo ? '0 : (int_hi ? IntMax : int_sum);
        kick_sum  = int_clamp + e_kp;
        code_sh   = kick_sum >>> FRAC_BITS;  // floor division
        code_lo   = code_sh < 0;
        code_hi   = code_sh > CodeMax;
        code_clamp = code_lo ? '0 : (code_hi ? {CODE_WIDTH{1'b1}} : code_sh[CODE_WIDTH-1:0]);
        e_net     = e_pos ? NW'(1) : (e_neg ? -(NW'(1)) : '0);
        net_sum   = net_q + e_net;
        net_abs   = (net_sum < 0) ? -net_sum : net_sum;
    end

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        code_d    = code_q;
        locked_d  = locked_q;
        sat_d     = sat_q;
        acq_cnt_d = acq_cnt_q;
        win_cnt_d = win_cnt_q;
        net_d     = net_q;

        if (ovr_load) begin
            int_d  = {ovr_code, {FRAC_BITS{1'b0}}};
            code_d = ovr_code;
            sat_d  = 1'b0;
            if (state_q != StIdle) begin
                state_d   = StAcq;
                acq_cnt_d = '0;
                win_cnt_d = '0;
                net_d     = '0;
                locked_d  = 1'b0;
            end
        end else if (update) begin
            int_d  = int_clamp[IW-1:0];
            code_d = code_clamp;
            sat_d  = int_lo | int_hi | code_lo | code_hi;
            if (state_q == StAcq) begin
                if (acq_last) begin
                    state_d   = StTrack;
                    acq_cnt_d = '0;
                    win_cnt_d = '0;
                    net_d     = '0;
                end else begin
                    acq_cnt_d = acq_cnt_q + 1'b1;
                end
            end else begin
                if (win_last) begin
                    locked_d  = (net_abs <= Thresh);
                    win_cnt_d = '0;
                    net_d     = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    net_d     = net_sum;
                end
            end
        end else begin
            // Proportional kick only lasts for the update that produced it.
            code_d = int_q[IW-1:FRAC_BITS];
        end

        if (!en) begin
            state_d  = StIdle;
            locked_d = 1'b0;
        end else if (state_q == StIdle) begin
            state_d   = StAcq;
            acq_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            int_q     <= IW'(CODE_INIT) << FRAC_BITS;
            code_q    <= CODE_WIDTH'(CODE_INIT);
            locked_q  <= 1'b0;
            sat_q     <= 1'b0;
            acq_cnt_q <= '0;
            win_cnt_q <= '0;
            net_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            code_q    <= code_d;
            locked_q  <= locked_d;
            sat_q     <= sat_d;
            acq_cnt_q <= acq_cnt_d;
            win_cnt_q <= win_cnt_d;
            net_q     <= net_d;
        end
    end

    assign code   = code_q;
    assign state  = state_q;
    assign locked = locked_q;
    assign sat    = sat_q;

endmodule
